// File: rtl/expr_eval.sv
// expr_eval
//    Arithmetic evaluator for the single-digit expression grammar
//    digit ((+|*) digit)*, consuming one ASCII character per clock.
//    Multiplication binds tighter than addition. The value of the longest
//    valid prefix ending on a digit is held in value; ok is high while the
//    characters so far form a complete valid expression.
//
// Parameters
//    WIDTH  width of the sum, product and value registers (minimum 4)
//
// Ports
//    clk    rising-edge clock, in is sampled on every edge
//    clr_n  asynchronous active-low reset
//    in     ASCII character ('0'-'9', '+', '*'; anything else is invalid)
//    ok     high when the stream so far is a complete valid expression
//    value  result of the longest valid prefix ending on a digit
//    ovf    sticky overflow flag
//
// Configuration
//    EXPR_EVAL_OVF_EN  when defined, ovf latches any wrap of a product,
//                      running sum or value sum until clr_n; otherwise ovf
//                      is tied low and arithmetic wraps silently.

module expr_eval #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [7:0]       in,
   output logic             ok,
   output logic [WIDTH-1:0] value,
   output logic             ovf
);

   typedef enum logic [1:0] {
      S_INIT,
      S_NUM,
      S_OP,
      S_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0] val_q, val_d;
   logic             mul_q, mul_d;

   logic             is_digit, is_plus, is_star;
   logic [WIDTH-1:0] digit;
   logic [WIDTH-1:0] mul_trunc;
   logic [WIDTH-1:0] new_prod;
   logic             use_mul;
   logic             do_digit;
   logic             do_plus;

   // Character decode. For '0'..'9' the low nibble is already the digit
   // value, so no subtraction is needed.
   assign is_digit  = (in >= 8'h30) && (in <= 8'h39);
   assign is_plus   = (in == 8'h2B);
   assign is_star   = (in == 8'h2A);
   assign digit     = WIDTH'(in[3:0]);
   assign mul_trunc = prod_q * digit;

   // A digit either starts a fresh product term or extends the current one,
   // depending on whether the operator just seen was '*'.
   assign use_mul  = (state_q == S_OP) && mul_q;
   assign new_prod = use_mul ? mul_trunc : digit;

   // Next-state and datapath update. S_ERR, and any transition into it,
   // leaves every register untouched so value keeps the last good result.
   always_comb begin
      state_d  = state_q;
      sum_d    = sum_q;
      prod_d   = prod_q;
      mul_d    = mul_q;
      val_d    = val_q;
      do_digit = 1'b0;
      do_plus  = 1'b0;
      case (state_q)
         S_INIT, S_OP: begin
            if (is_digit) begin
               state_d  = S_NUM;
               do_digit = 1'b1;
               prod_d   = new_prod;
               val_d    = sum_q + new_prod;
            end else begin
               state_d = S_ERR;
            end
         end
         S_NUM: begin
            if (is_plus) begin
               state_d = S_OP;
               do_plus = 1'b1;
               sum_d   = sum_q + prod_q;
               mul_d   = 1'b0;
            end else if (is_star) begin
               state_d = S_OP;
               mul_d   = 1'b1;
            end else begin
               state_d = S_ERR;
            end
         end
         default: begin
            state_d = S_ERR;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= S_INIT;
         sum_q   <= '0;
         prod_q  <= '0;
         val_q   <= '0;
         mul_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         prod_q  <= prod_d;
         val_q   <= val_d;
         mul_q   <= mul_d;
      end
   end

   assign ok    = (state_q == S_NUM);
   assign value = val_q;

`ifdef EXPR_EVAL_OVF_EN
   localparam int PW = WIDTH + 4;

   logic [PW-1:0]  prod_wide;
   logic [WIDTH:0] val_wide;
   logic [WIDTH:0] sum_wide;
   logic           ovf_set;
   logic           ovf_q;

   // Widened copies of the three arithmetic paths; any bit above WIDTH
   // means the stored (truncated) result has wrapped.
   assign prod_wide = PW'(prod_q) * PW'(in[3:0]);
   assign val_wide  = {1'b0, sum_q} + {1'b0, new_prod};
   assign sum_wide  = {1'b0, sum_q} + {1'b0, prod_q};

   always_comb begin
      ovf_set = 1'b0;
      if (do_digit && use_mul && (prod_wide[PW-1:WIDTH] != '0)) begin
         ovf_set = 1'b1;
      end
      if (do_digit && val_wide[WIDTH]) begin
         ovf_set = 1'b1;
      end
      if (do_plus && sum_wide[WIDTH]) begin
         ovf_set = 1'b1;
      end
   end

   // Sticky flag, cleared only by reset.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         ovf_q <= 1'b0;
      end else if (ovf_set) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_expr_eval.sv
// tb_expr_eval
//    Directed and model-driven checks for expr_eval. Two instances share the
//    character stream: the default 16-bit build and an 8-bit build used for
//    the wrap/overflow cases.

module tb_expr_eval;

   logic        clk;
   logic        clr_n;
   logic [7:0]  in;
   logic        ok16;
   logic [15:0] value16;
   logic        ovf16;
   logic        ok8;
   logic [7:0]  value8;
   logic        ovf8;

   int checkCount;
   int passCount;

   expr_eval #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .clr_n (clr_n),
      .in    (in),
      .ok    (ok16),
      .value (value16),
      .ovf   (ovf16)
   );

   expr_eval #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .clr_n (clr_n),
      .in    (in),
      .ok    (ok8),
      .value (value8),
      .ovf   (ovf8)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Present one character (releasing reset if it was held), let the next
   // rising edge sample it, and return just after that edge.
   task automatic applyStimulus(input logic [7:0] ch);
      @(negedge clk);
      clr_n = 1'b1;
      in    = ch;
      @(posedge clk);
      #1;
   endtask

   // Assert reset between edges and hold it across one rising edge.
   task automatic pulseReset();
      #2;
      clr_n = 1'b0;
      in    = 8'h00;
      #1;
      @(posedge clk);
      #1;
   endtask

   // Reference model state for the random stream.
   int          mState;
   logic [15:0] mSum, mProd, mVal;
   bit          mMul;

   task automatic modelReset();
      mState = 0;
      mSum   = '0;
      mProd  = '0;
      mVal   = '0;
      mMul   = 1'b0;
   endtask

   // Grammar/arithmetic model: 0=start, 1=after digit, 2=after operator, 3=error.
   task automatic modelStep(input logic [7:0] ch);
      int d;
      d = int'(ch) - 48;
      if (mState == 0 || mState == 2) begin
         if (d >= 0 && d <= 9) begin
            if (mState == 2 && mMul) mProd = 16'(int'(mProd) * d);
            else                     mProd = 16'(d);
            mVal   = 16'(int'(mSum) + int'(mProd));
            mState = 1;
         end else begin
            mState = 3;
         end
      end else if (mState == 1) begin
         if (ch == "+") begin
            mSum   = 16'(int'(mSum) + int'(mProd));
            mMul   = 1'b0;
            mState = 2;
         end else if (ch == "*") begin
            mMul   = 1'b1;
            mState = 2;
         end else begin
            mState = 3;
         end
      end
   endtask

   initial begin
      string       s;
      int          exp2 [7];
      logic [7:0]  ch;
      int          r;
      int          expOvf;

      checkCount = 0;
      passCount  = 0;
      clr_n      = 1'b1;
      in         = 8'h00;

      // Reset state
      pulseReset();
      checkOutput("reset_ok", int'(ok16), 0);
      checkOutput("reset_value", int'(value16), 0);
      checkOutput("reset_ovf", int'(ovf16), 0);

      // "1+2*3" = 7, intermediate "1+2" = 3
      s = "1+2*3";
      for (int i = 0; i < s.len(); i++) begin
         applyStimulus(s[i]);
         if (i == 2) checkOutput("1+2_value", int'(value16), 3);
      end
      checkOutput("1+2*3_ok", int'(ok16), 1);
      checkOutput("1+2*3_value", int'(value16), 7);

      // "2*3+4*5": value trace and ok alternation
      pulseReset();
      s = "2*3+4*5";
      exp2 = '{2, 2, 6, 6, 10, 10, 26};
      for (int i = 0; i < s.len(); i++) begin
         applyStimulus(s[i]);
         checkOutput($sformatf("2*3+4*5_value[%0d]", i), int'(value16), exp2[i]);
         checkOutput($sformatf("2*3+4*5_ok[%0d]", i), int'(ok16), (i % 2 == 0) ? 1 : 0);
      end

      // "5++" then digits: error state absorbs, value frozen at 5
      pulseReset();
      applyStimulus("5");
      applyStimulus("+");
      checkOutput("5+_ok", int'(ok16), 0);
      checkOutput("5+_value", int'(value16), 5);
      applyStimulus("+");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8'(8'h31 + i));
         checkOutput($sformatf("err_ok[%0d]", i), int'(ok16), 0);
         checkOutput($sformatf("err_value[%0d]", i), int'(value16), 5);
      end

      // "7*" then asynchronous reset mid-cycle, then "4"
      pulseReset();
      applyStimulus("7");
      applyStimulus("*");
      #2;
      clr_n = 1'b0;
      #1;
      checkOutput("async_rst_ok", int'(ok16), 0);
      checkOutput("async_rst_value", int'(value16), 0);
      @(posedge clk);
      #1;
      applyStimulus("4");
      checkOutput("after_rst_ok", int'(ok16), 1);
      checkOutput("after_rst_value", int'(value16), 4);

      // "9*9*9" then "+1": wrap at 8 bits, no wrap at 16 bits
`ifdef EXPR_EVAL_OVF_EN
      expOvf = 1;
`else
      expOvf = 0;
`endif
      pulseReset();
      s = "9*9*9";
      for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
      checkOutput("w8_999_value", int'(value8), 217);
      checkOutput("w8_999_ovf", int'(ovf8), expOvf);
      checkOutput("w16_999_value", int'(value16), 729);
      checkOutput("w16_999_ovf", int'(ovf16), 0);
      applyStimulus("+");
      applyStimulus("1");
      checkOutput("w8_999+1_value", int'(value8), 218);
      checkOutput("w8_999+1_ovf", int'(ovf8), expOvf);
      checkOutput("w16_999+1_value", int'(value16), 730);
      pulseReset();
      checkOutput("ovf_cleared", int'(ovf8), 0);

      // Leading '+' goes to error; a later digit must not recover
      applyStimulus("+");
      checkOutput("lead_plus_ok", int'(ok16), 0);
      applyStimulus("3");
      checkOutput("lead_plus_stuck_ok", int'(ok16), 0);
      checkOutput("lead_plus_value", int'(value16), 0);

      // 'A' after a digit goes to error; value keeps the digit
      pulseReset();
      applyStimulus("3");
      applyStimulus(8'h41);
      checkOutput("A_ok", int'(ok16), 0);
      checkOutput("A_value", int'(value16), 3);
      applyStimulus("4");
      checkOutput("A_stuck_ok", int'(ok16), 0);
      checkOutput("A_stuck_value", int'(value16), 3);

      // 200-character biased random stream with reset pulses
      pulseReset();
      modelReset();
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            pulseReset();
            modelReset();
            checkOutput("rnd_rst_ok", int'(ok16), 0);
         end
         r = int'($urandom_range(0, 19));
         if (r == 0)      ch = 8'h41;
         else if (r == 1) ch = 8'h00;
         else if (mState == 1) ch = (r < 11) ? 8'h2B : 8'h2A;
         else             ch = 8'(8'h30 + $urandom_range(0, 9));
         applyStimulus(ch);
         modelStep(ch);
         checkOutput($sformatf("rnd_ok[%0d]", i), int'(ok16), (mState == 1) ? 1 : 0);
         checkOutput($sformatf("rnd_value[%0d]", i), int'(value16), int'(mVal));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
